seq_restoring_divider: RTL

- Iterative unsigned restoring divider built on the team's ripple add/subtract datapath.
- Each cycle performs one trial subtraction: add the inverted divisor with carry-in 1, then use carry-out as the no-borrow flag.
- Consumes the subtractor's sum and carry-out and turns them into quotient and remainder over WIDTH cycles.
- Sits beside the ALU as its multi-cycle divide unit, with a start/busy/done handshake.

---
 rtl/seq_restoring_divider.sv | 114 +++++++++++
 1 files changed

// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider: one ripple trial subtraction per cycle,
// WIDTH iterations per divide, with a start/busy/done handshake.
module seq_restoring_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Handshake: start is accepted at any edge where start=1 and busy=0
  // (IDLE or DONE); busy=1 only in RUN; done is a one-cycle pulse in DONE.
  state_t           state, state_next;
  logic [WIDTH-1:0] q, d;
  // The partial remainder is always below the divisor after each step, so its
  // top bit is structurally zero and only WIDTH bits are kept.
  logic [WIDTH-1:0] r;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   r_shift, sub_b;
  logic [WIDTH-1:0] t;
  logic [WIDTH+1:0] carry;
  logic             no_borrow;
  logic             accept;
  logic [WIDTH-1:0] q_next, r_next;

  // Ripple subtract: r_shift + ~{0,d} + 1; carry-out high means no borrow.
  always_comb begin
    r_shift  = {r, q[WIDTH-1]};
    sub_b    = ~{1'b0, d};
    t        = '0;
    carry    = '0;
    carry[0] = 1'b1;
    for (int i = 0; i <= WIDTH; i++) begin
      if (i < WIDTH) t[i] = r_shift[i] ^ sub_b[i] ^ carry[i];
      carry[i+1] = (r_shift[i] & sub_b[i]) | (carry[i] & (r_shift[i] ^ sub_b[i]));
    end
    no_borrow = carry[WIDTH+1];
    r_next    = no_borrow ? t : r_shift[WIDTH-1:0];
    q_next    = {q[WIDTH-2:0], no_borrow};
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        accept = start;
        if (start) state_next = (divisor != '0) ? RUN : DONE;
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == CW'(1)) state_next = DONE;
      end
      DONE: begin
        done   = 1'b1;
        accept = start;
        if (start) state_next = (divisor != '0) ? RUN : DONE;
        else       state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      q           <= '0;
      r           <= '0;
      d           <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        if (divisor != '0) begin
          q           <= dividend;
          r           <= '0;
          d           <= divisor;
          cnt         <= CW'(WIDTH);
          div_by_zero <= 1'b0;
        end else begin
          quotient    <= '1;
          remainder   <= dividend;
          div_by_zero <= 1'b1;
        end
      end else if (state == RUN) begin
        q   <= q_next;
        r   <= r_next;
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          quotient  <= q_next;
          remainder <= r_next;
        end
      end
    end
  end

endmodule
